// File: rtl/ps2_text_buffer_if.sv
// Character handshake between the scan-code decoder and the text buffer.
// The decoder drives one ASCII code per strobe.
// The buffer answers with key_ready.
interface ps2_text_buffer_if;
  logic [7:0] asc;
  logic       asc_valid;
  logic       key_ready;

  modport master (
    output asc,
    output asc_valid,
    input  key_ready
  );

  modport slave (
    input  asc,
    input  asc_valid,
    output key_ready
  );
endinterface

// File: rtl/ps2_text_buffer.sv
// ROWS x COLS character screen with a cursor.
// Handles printable characters, backspace, newline, auto-wrap and scroll.
// Scrolling is done by rotating top_row, not by moving memory.
// The newly exposed bottom line is then blanked over COLS cycles (CLEAR).
// The read port takes logical coordinates and has one cycle of latency.
module ps2_text_buffer #(
  parameter int unsigned COLS = 70,
  parameter int unsigned ROWS = 30,
  parameter int unsigned CW   = $clog2(COLS),
  parameter int unsigned RW   = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ps2_text_buffer_if.slave      key,
  input  logic [RW-1:0]         rd_row,
  input  logic [CW-1:0]         rd_col,
  output logic [7:0]            rd_data,
  output logic [RW-1:0]         cursor_row,
  output logic [CW-1:0]         cursor_col,
  output logic                  line_done,
  output logic                  overflow
);

  localparam int unsigned Depth = ROWS * COLS;
  localparam int unsigned AW    = $clog2(Depth);
  localparam logic [7:0]  Space = 8'h20;

  typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

  state_e          state_q;
  logic [AW-1:0]   init_addr_q;
  logic [CW-1:0]   clr_col_q;
  logic [RW-1:0]   cursor_row_q;
  logic [CW-1:0]   cursor_col_q;
  logic [RW-1:0]   top_row_q;
  logic            line_done_q;
  logic            overflow_q;
  logic            key_ready_q;

  logic [7:0]      mem [Depth];

  // (base + offs) mod ROWS; both operands are already below ROWS.
  function automatic logic [RW-1:0] wrap_row(input logic [RW-1:0] base,
                                             input logic [RW-1:0] offs);
    logic [RW:0] sum;
    sum = {1'b0, base} + {1'b0, offs};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    return sum[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] phys_addr(input logic [RW-1:0] row,
                                              input logic [CW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  logic            accept;
  logic            is_print;
  logic            is_bs;
  logic            is_nl;
  logic            at_last_col;
  logic            advance;
  logic [RW-1:0]   cur_phys;
  logic [RW-1:0]   bot_phys;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  // Decode the incoming character and select the single memory write for this cycle.
  always_comb begin
    accept      = key.asc_valid && key_ready_q;
    is_print    = (key.asc >= 8'h20) && (key.asc <= 8'h7e);
    is_bs       = (key.asc == 8'h08);
    is_nl       = (key.asc == 8'h0a) || (key.asc == 8'h0d);
    at_last_col = (cursor_col_q == CW'(COLS - 1));
    advance     = accept && (is_nl || (is_print && at_last_col));
    cur_phys    = wrap_row(top_row_q, cursor_row_q);
    // After a scroll, the new bottom line is the physical row just above top_row.
    bot_phys    = (top_row_q == '0) ? RW'(ROWS - 1) : top_row_q - 1'b1;
    we          = 1'b0;
    waddr       = '0;
    wdata       = Space;
    case (state_q)
      StInit: begin
        we    = 1'b1;
        waddr = init_addr_q;
      end
      StClear: begin
        we    = 1'b1;
        waddr = phys_addr(bot_phys, clr_col_q);
      end
      StIdle: begin
        if (accept && is_print) begin
          we    = 1'b1;
          waddr = phys_addr(cur_phys, cursor_col_q);
          wdata = key.asc;
        end else if (accept && is_bs && (cursor_col_q != '0)) begin
          we    = 1'b1;
          waddr = phys_addr(cur_phys, cursor_col_q - 1'b1);
        end
      end
      default: ;
    endcase
  end

  // Character memory write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [RW-1:0]   rd_phys;
  logic            rd_ok;
  logic [AW-1:0]   raddr;

  // Logical-to-physical translation for the read port.
  // Out-of-range coordinates read as zero.
  always_comb begin
    rd_ok   = ({1'b0, rd_row} < (RW+1)'(ROWS)) && ({1'b0, rd_col} < (CW+1)'(COLS));
    rd_phys = wrap_row(top_row_q, rd_ok ? rd_row : '0);
    raddr   = phys_addr(rd_phys, rd_ok ? rd_col : '0);
  end

  // Registered read; a same-edge write to the same address returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= rd_ok ? mem[raddr] : 8'h00;
    end
  end

  // Control FSM: init sweep, character editing, bottom-line clear after a scroll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      init_addr_q  <= '0;
      clr_col_q    <= '0;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      top_row_q    <= '0;
      line_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      key_ready_q  <= 1'b0;
    end else begin
      line_done_q <= 1'b0;
      if (key.asc_valid && !key_ready_q) overflow_q <= 1'b1;
      case (state_q)
        StInit: begin
          if (init_addr_q == AW'(Depth - 1)) begin
            state_q     <= StIdle;
            key_ready_q <= 1'b1;
          end else begin
            init_addr_q <= init_addr_q + 1'b1;
          end
        end
        StIdle: begin
          if (accept) begin
            if (is_print) begin
              cursor_col_q <= at_last_col ? '0 : cursor_col_q + 1'b1;
            end else if (is_bs) begin
              if (cursor_col_q != '0) cursor_col_q <= cursor_col_q - 1'b1;
            end else if (is_nl) begin
              cursor_col_q <= '0;
              line_done_q  <= 1'b1;
            end
          end
          if (advance) begin
            if (cursor_row_q != RW'(ROWS - 1)) begin
              cursor_row_q <= cursor_row_q + 1'b1;
            end else begin
              top_row_q   <= (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + 1'b1;
              clr_col_q   <= '0;
              state_q     <= StClear;
              key_ready_q <= 1'b0;
            end
          end
        end
        StClear: begin
          if (clr_col_q == CW'(COLS - 1)) begin
            state_q     <= StIdle;
            key_ready_q <= 1'b1;
          end else begin
            clr_col_q <= clr_col_q + 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign key.key_ready = key_ready_q;
  assign cursor_row    = cursor_row_q;
  assign cursor_col    = cursor_col_q;
  assign line_done     = line_done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_text_buffer.sv
// Self-checking bench for ps2_text_buffer.
// The reference screen is a logical ROWS x COLS array.
// On a scroll it shifts its rows up, which is independent of the DUT's top_row rotation.
module tb_ps2_text_buffer;
  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [7:0]    rd_data;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic          line_done;
  logic          overflow;

  ps2_text_buffer_if key ();

  ps2_text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .line_done  (line_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // Reference screen and cursor.
  logic [7:0] scr [ROWS][COLS];
  int mr, mc;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    mr = 0;
    mc = 0;
  endfunction

  function automatic void model_down();
    if (mr < ROWS - 1) begin
      mr++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
    end
  endfunction

  // Returns the expected line_done for this character.
  function automatic bit model_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7e) begin
      scr[mr][mc] = ch;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        model_down();
      end
      return 1'b0;
    end
    if (ch == 8'h08) begin
      if (mc > 0) begin
        mc--;
        scr[mr][mc] = 8'h20;
      end
      return 1'b0;
    end
    if (ch == 8'h0a || ch == 8'h0d) begin
      mc = 0;
      model_down();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_code();
    int k;
    k = $urandom_range(0, 99);
    if (k < 70) return 8'($urandom_range(32, 126));
    if (k < 80) return 8'h08;
    if (k < 86) return 8'h0a;
    if (k < 89) return 8'h0d;
    if (k < 94) return 8'h00;
    if (k < 97) return 8'($urandom_range(1, 7));
    return 8'($urandom_range(127, 255));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for key_ready, then present one character for exactly one edge.
  task automatic send_char(input logic [7:0] ch, output bit ld);
    int n;
    n = 0;
    while (key.key_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (key.key_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL send_wait key_ready=%b required 1", key.key_ready);
    end
    key.asc       = ch;
    key.asc_valid = 1'b1;
    tick();
    key.asc_valid = 1'b0;
    ld = line_done;
  endtask

  // Reset, check reset values, and check that INIT lasts exactly ROWS*COLS cycles.
  // A non-negative strobe_at pulses asc_valid at that INIT cycle.
  task automatic test_reset_seq(input int strobe_at);
    key.asc       = 8'h00;
    key.asc_valid = 1'b0;
    rd_row        = '0;
    rd_col        = '0;
    rst_n         = 1'b0;
    #1;
    checks++;
    if ({key.key_ready, line_done, overflow} !== 3'b000 || rd_data !== 8'h00 ||
        cursor_row !== '0 || cursor_col !== '0) begin
      fails++;
      $display("FAIL reset_values kr=%b ld=%b ov=%b rd=%h cur=(%0d,%0d) required all zero",
               key.key_ready, line_done, overflow, rd_data, cursor_row, cursor_col);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < ROWS * COLS - 1; i++) begin
      if (i == strobe_at) begin
        key.asc       = 8'h51;
        key.asc_valid = 1'b1;
      end
      tick();
      key.asc_valid = 1'b0;
    end
    checks++;
    if (key.key_ready !== 1'b0) begin
      fails++;
      $display("FAIL init_len_early key_ready=%b required 0", key.key_ready);
    end
    tick();
    checks++;
    if (key.key_ready !== 1'b1) begin
      fails++;
      $display("FAIL init_len key_ready=%b required 1", key.key_ready);
    end
    model_clear();
  endtask

  task automatic test_screen(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rd_row = RW'(r);
        rd_col = CW'(c);
        tick();
        checks++;
        if (rd_data !== scr[r][c]) begin
          fails++;
          $display("FAIL %s cell(%0d,%0d) got %h required %h", tag, r, c, rd_data, scr[r][c]);
        end
      end
    end
  endtask

  task automatic test_cursor(input string tag);
    checks++;
    if (cursor_row !== RW'(mr) || cursor_col !== CW'(mc)) begin
      fails++;
      $display("FAIL %s cursor got (%0d,%0d) required (%0d,%0d)",
               tag, cursor_row, cursor_col, mr, mc);
    end
  endtask

  task automatic test_reset();
    test_reset_seq(-1);
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_overflow got %b required 0", overflow);
    end
    test_screen("init_blank");
  endtask

  task automatic test_print();
    bit ld;
    test_reset_seq(-1);
    void'(model_apply(8'h48));
    send_char(8'h48, ld);
    void'(model_apply(8'h69));
    send_char(8'h69, ld);
    checks++;
    if (cursor_row !== '0 || cursor_col !== CW'(2)) begin
      fails++;
      $display("FAIL print_cursor got (%0d,%0d) required (0,2)", cursor_row, cursor_col);
    end
    test_screen("print_hi");
  endtask

  task automatic test_backspace();
    bit ld;
    test_reset_seq(-1);
    void'(model_apply(8'h41));
    send_char(8'h41, ld);
    void'(model_apply(8'h08));
    send_char(8'h08, ld);
    checks++;
    if (cursor_col !== '0) begin
      fails++;
      $display("FAIL bs_first cursor_col got %0d required 0", cursor_col);
    end
    void'(model_apply(8'h08));
    send_char(8'h08, ld);
    checks++;
    if (cursor_col !== '0 || cursor_row !== '0) begin
      fails++;
      $display("FAIL bs_col0 cursor got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
    test_screen("backspace");
  endtask

  task automatic test_back_to_back_wrap();
    bit ld;
    int pulses;
    int unsigned start;
    test_reset_seq(-1);
    pulses = 0;
    start  = cyc;
    for (int i = 0; i <= COLS; i++) begin
      logic [7:0] ch;
      ch = (i < COLS) ? 8'h78 : 8'h79;
      void'(model_apply(ch));
      send_char(ch, ld);
      if (ld) pulses++;
    end
    checks++;
    if (cyc - start != COLS + 1) begin
      fails++;
      $display("FAIL back_to_back cycles got %0d required %0d", cyc - start, COLS + 1);
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL wrap_line_done pulses got %0d required 0", pulses);
    end
    checks++;
    if (cursor_row !== RW'(1) || cursor_col !== CW'(1)) begin
      fails++;
      $display("FAIL wrap_cursor got (%0d,%0d) required (1,1)", cursor_row, cursor_col);
    end
    void'(model_apply(8'h00));
    send_char(8'h00, ld);
    test_cursor("release_code");
    test_screen("wrap");
  endtask

  task automatic test_scroll();
    bit ld;
    int pulses;
    int n;
    test_reset_seq(-1);
    void'(model_apply(8'h5a));
    send_char(8'h5a, ld);
    pulses = 0;
    for (int i = 0; i < ROWS; i++) begin
      void'(model_apply(8'h0a));
      send_char(8'h0a, ld);
      if (ld) pulses++;
    end
    checks++;
    if (pulses != ROWS) begin
      fails++;
      $display("FAIL scroll_line_done pulses got %0d required %0d", pulses, ROWS);
    end
    n = 0;
    while (key.key_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != COLS) begin
      fails++;
      $display("FAIL clear_len key_ready low cycles got %0d required %0d", n, COLS);
    end
    checks++;
    if (cursor_row !== RW'(ROWS - 1) || cursor_col !== '0) begin
      fails++;
      $display("FAIL scroll_cursor got (%0d,%0d) required (%0d,0)",
               cursor_row, cursor_col, ROWS - 1);
    end
    test_screen("scroll");
  endtask

  task automatic test_random();
    bit ld;
    bit exp_ld;
    logic [7:0] ch;
    test_reset_seq(-1);
    for (int i = 0; i < 800; i++) begin
      ch     = rand_code();
      exp_ld = model_apply(ch);
      send_char(ch, ld);
      checks++;
      if (ld !== exp_ld) begin
        fails++;
        $display("FAIL rand_line_done code %h got %b required %b", ch, ld, exp_ld);
      end
      test_cursor("rand");
    end
    test_screen("random");
  endtask

  task automatic test_overflow_reset();
    bit ld;
    test_reset_seq(700);
    checks++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky got %b required 1", overflow);
    end
    test_screen("overflow_dropped");
    for (int i = 0; i < ROWS; i++) begin
      void'(model_apply(8'h0d));
      send_char(8'h0d, ld);
    end
    repeat (5) tick();
    key.asc       = 8'h41;
    key.asc_valid = 1'b1;
    tick();
    key.asc_valid = 1'b0;
    checks++;
    if (key.key_ready !== 1'b0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear kr=%b ov=%b required kr=0 ov=1", key.key_ready, overflow);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key.key_ready, line_done, overflow} !== 3'b000 || rd_data !== 8'h00 ||
        cursor_row !== '0 || cursor_col !== '0) begin
      fails++;
      $display("FAIL reset_mid_clear kr=%b ld=%b ov=%b rd=%h cur=(%0d,%0d) required all zero",
               key.key_ready, line_done, overflow, rd_data, cursor_row, cursor_col);
    end
    test_reset_seq(-1);
    test_screen("after_clear_reset");
  endtask

  initial begin
    test_reset();
    test_print();
    test_backspace();
    test_back_to_back_wrap();
    test_scroll();
    test_random();
    test_overflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
